// File: rtl/kbd_xt_scheduler_if.sv
// Host-side scancode handshake and emulator-side load/ack signals for kbd_xt_scheduler.
interface kbd_xt_scheduler_if;
  logic [7:0] host_code;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] emu_code;
  logic       emu_load;
  logic       emu_irq;
  logic       emu_clear;
  logic       emu_reset_kbd;

  // Environment side: host controller plus set-2-to-set-1 emulator.
  modport master (
    output host_code, host_valid, emu_irq,
    input  host_ready, emu_code, emu_load, emu_clear, emu_reset_kbd
  );

  // Scheduler side.
  modport slave (
    input  host_code, host_valid, emu_irq,
    output host_ready, emu_code, emu_load, emu_clear, emu_reset_kbd
  );
endinterface

// File: rtl/kbd_xt_scheduler.sv
// XT keyboard scheduler: queues host set-2 scancodes, feeds them one at a time to the
// set-2-to-set-1 emulator, waits for the CPU acknowledge, and emulates keyboard reset/self-test.
module kbd_xt_scheduler #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned RST_LOW  = 16'd4000,
  parameter int unsigned SELFTEST = 16'd8000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  kbd_xt_scheduler_if.slave        bus,
  input  logic                     kbd_clk_en,
  input  logic                     kbd_clear,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StPrefix, StWaitAck, StRstHold, StRstDelay} state_e;

  state_e        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [15:0]   rst_cnt;
  logic [15:0]   dly_cnt;
  logic          clear_q;

  logic       full;
  logic       empty;
  logic       rst_hit;
  logic       clear_rise;
  logic       wr_attempt;
  logic       push;
  logic       pop;
  logic [7:0] wr_byte;
  logic [7:0] head;

  assign full       = (level == (AW+1)'(DEPTH));
  assign empty      = (level == '0);
  // Fires exactly once, on the RST_LOW-th consecutive low sample; counter then saturates.
  assign rst_hit    = !kbd_clk_en && (rst_cnt == 16'(RST_LOW - 1));
  assign clear_rise = kbd_clear && !clear_q;
  // Writes during RST_HOLD vanish without touching overflow.
  assign wr_attempt = bus.host_valid && (state != StRstHold);
  assign push       = wr_attempt && !full && (bus.host_code != 8'h00) && !rst_hit;
  assign wr_byte    = (bus.host_code == 8'hF0) ? 8'hFF : bus.host_code;
  assign head       = mem[rd_ptr];
  assign pop        = !rst_hit && !empty &&
                      (((state == StIdle) && !bus.emu_irq && !kbd_clear && kbd_clk_en) ||
                       (state == StPrefix));

  assign bus.host_ready = !full && (state != StRstHold);
  assign fifo_level     = level;

  // Scancode storage; contents need no reset since occupancy is tracked by level.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_byte;
  end

  // FIFO pointers, occupancy and sticky overflow; a keyboard reset flushes everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (rst_hit) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (!push && pop) level <= level - (AW+1)'(1);
      if (wr_attempt && full) overflow <= 1'b1;
    end
  end

  // Consecutive-low counter on kbd_clk_en plus registered kbd_clear for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt <= '0;
      clear_q <= 1'b0;
    end else begin
      clear_q <= kbd_clear;
      if (kbd_clk_en)                    rst_cnt <= '0;
      else if (rst_cnt != 16'(RST_LOW))  rst_cnt <= rst_cnt + 16'd1;
    end
  end

  // Scheduler FSM with registered emulator outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= StIdle;
      dly_cnt           <= '0;
      bus.emu_code      <= 8'h00;
      bus.emu_load      <= 1'b0;
      bus.emu_clear     <= 1'b0;
      bus.emu_reset_kbd <= 1'b0;
    end else begin
      bus.emu_load      <= 1'b0;
      bus.emu_clear     <= 1'b0;
      bus.emu_reset_kbd <= 1'b0;
      if (rst_hit) begin
        state   <= StRstHold;
        dly_cnt <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (pop) begin
              bus.emu_code <= head;
              bus.emu_load <= 1'b1;
              state        <= (head == 8'hFF) ? StPrefix : StWaitAck;
            end
          end
          StPrefix: begin
            if (pop) begin
              bus.emu_code <= head;
              bus.emu_load <= 1'b1;
              state        <= StWaitAck;
            end
          end
          StWaitAck: begin
            if (clear_rise && bus.emu_irq) begin
              bus.emu_clear <= 1'b1;
              state         <= StIdle;
            end
          end
          StRstHold: begin
            // Release cycle counts as the first self-test cycle.
            if (kbd_clk_en) begin
              state   <= StRstDelay;
              dly_cnt <= 16'd1;
            end
          end
          StRstDelay: begin
            if (!kbd_clk_en) begin
              state   <= StIdle;
              dly_cnt <= '0;
            end else if (dly_cnt >= 16'(SELFTEST - 1)) begin
              bus.emu_reset_kbd <= 1'b1;
              state             <= StWaitAck;
              dly_cnt           <= '0;
            end else begin
              dly_cnt <= dly_cnt + 16'd1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end
endmodule
